// File: rtl/lut_table_loader.sv
// lut_table_loader
//   Holds a 2**IN_BITS x 1 truth table for a LUT neuron. The table is written
//   one byte at a time over a valid/ready config stream and then looked up by
//   operands arriving on a valid/ready input stream. The result goes out
//   through a single-entry output register with valid/ready handshaking.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   cfg_valid  config byte offered
//   cfg_ready  config byte accepted (always 1)
//   cfg_data   eight consecutive table entries, bit 0 = lowest index
//   cfg_last   marks the final byte of a table
//   in_valid   lookup operand offered
//   in_ready   operand accepted
//   in_data    LUT index
//   out_valid  result held in the output register
//   out_ready  downstream consumes the result
//   out_data   looked-up table entry
//   loaded     a complete, correctly framed table is present
//   load_err   sticky framing error from the last load
module lut_table_loader #(
  parameter int IN_BITS = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [7:0]         cfg_data,
  input  logic               cfg_last,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_BITS-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_data,
  output logic               loaded,
  output logic               load_err
);

  localparam int NUM_ENTRIES = 2 ** IN_BITS;
  localparam int NUM_BYTES   = NUM_ENTRIES / 8;
  // Counter is kept at least one bit wide so IN_BITS=3 (a single byte) works.
  localparam int CW          = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST_POS = CW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    ARMED   = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                loaded_n, load_err_n;
  logic [CW-1:0]       pos;
  logic [NUM_ENTRIES-1:0] table_q;
  logic                in_xfer;

  assign cfg_ready = 1'b1;

  // A transfer outside LOADING starts a new table at byte 0.
  assign pos = (state == LOADING) ? cnt : '0;

  // Config traffic blocks lookups combinationally so the two never share a cycle.
  assign in_ready = (state == ARMED) && !cfg_valid && (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    loaded_n   = loaded;
    load_err_n = load_err;
    if (cfg_valid) begin
      if (state != LOADING) begin
        loaded_n   = 1'b0;
        load_err_n = 1'b0;
      end
      if (pos == LAST_POS) begin
        cnt_n = '0;
        if (cfg_last) begin
          loaded_n = 1'b1;
          state_n  = ARMED;
        end else begin
          load_err_n = 1'b1;
          state_n    = EMPTY;
        end
      end else if (cfg_last) begin
        cnt_n      = '0;
        load_err_n = 1'b1;
        state_n    = EMPTY;
      end else begin
        cnt_n   = pos + 1'b1;
        state_n = LOADING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      cnt      <= '0;
      loaded   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      loaded   <= loaded_n;
      load_err <= load_err_n;
    end
  end

  // Table storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && cfg_valid) begin
      table_q[{pos, 3'b000} +: 8] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= table_q[in_data];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_table_loader.sv
// tb_lut_table_loader
//   Directed bench for lut_table_loader (IN_BITS=6): load framing, lookups,
//   backpressure, reload with a pending result, and reset mid-load.
module tb_lut_table_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready, cfg_last;
  logic [7:0] cfg_data;
  logic       in_valid, in_ready;
  logic [5:0] in_data;
  logic       out_valid, out_ready, out_data;
  logic       loaded, load_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lut_table_loader #(.IN_BITS(6)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .loaded(loaded), .load_err(load_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    step();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic load_table(input logic [7:0] d);
    for (int k = 0; k < 8; k++) send_byte(d, k == 7);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_loaded", loaded, 0);
    check("rst_err", load_err, 0);
    check("rst_ov", out_valid, 0);
    check("rst_od", out_data, 0);
    check("rst_inrdy", in_ready, 0);
    check("cfg_ready", cfg_ready, 1);

    // Table of 0xAA: entry i = i[0].
    for (int k = 0; k < 8; k++) begin
      send_byte(8'hAA, k == 7);
      if (k == 3) check("mid_loaded", loaded, 0);
    end
    check("aa_loaded", loaded, 1);
    check("aa_err", load_err, 0);

    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = 6'(i);
      #1;
      check("aa_inrdy", in_ready, 1);
      step();
      check("aa_ov", out_valid, 1);
      check("aa_od", out_data, i % 2);
    end
    in_valid = 1'b0;
    step();
    check("aa_drain", out_valid, 0);

    // Config has priority over a lookup offered the same cycle.
    cfg_valid = 1'b1; cfg_data = 8'h00; cfg_last = 1'b0; in_valid = 1'b1;
    #1;
    check("prio_inrdy", in_ready, 0);
    step();
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    check("prio_ov", out_valid, 0);
    check("start_loaded", loaded, 0);
    // Early cfg_last on byte 3.
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    check("early_err", load_err, 1);
    check("early_loaded", loaded, 0);
    in_valid = 1'b1;
    #1;
    check("early_inrdy", in_ready, 0);
    in_valid = 1'b0;

    // Missing cfg_last on byte 7.
    for (int k = 0; k < 8; k++) begin
      send_byte(8'h55, 1'b0);
      if (k == 0) check("restart_err", load_err, 0);
      if (k == 6) check("nolast_err6", load_err, 0);
    end
    check("nolast_err", load_err, 1);
    check("nolast_loaded", loaded, 0);

    // Backpressure.
    load_table(8'hAA);
    check("bp_loaded", loaded, 1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 6'd5;
    step();
    check("bp_ov", out_valid, 1);
    check("bp_od", out_data, 1);
    in_data = 6'd4;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_hold_inrdy", in_ready, 0);
      check("bp_hold_od", out_data, 1);
      check("bp_hold_ov", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_inrdy", in_ready, 1);
    step();
    check("b2b_od0", out_data, 0);
    in_data = 6'd7;
    step();
    check("b2b_od1", out_data, 1);
    check("b2b_ov1", out_valid, 1);
    in_data = 6'd6;
    step();
    check("b2b_od2", out_data, 0);
    in_valid = 1'b0;
    step();
    check("b2b_drain", out_valid, 0);

    // Reload to 0xFF with a pending result (entry 2 of 0xAA = 0).
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 6'd2;
    step();
    in_valid = 1'b0;
    check("pend_ov", out_valid, 1);
    check("pend_od", out_data, 0);
    for (int k = 0; k < 8; k++) begin
      send_byte(8'hFF, k == 7);
      if (k == 4) begin
        in_valid = 1'b1;
        #1;
        check("reload_inrdy", in_ready, 0);
        in_valid = 1'b0;
      end
    end
    check("ff_loaded", loaded, 1);
    check("pend_ov_kept", out_valid, 1);
    check("pend_od_kept", out_data, 0);
    out_ready = 1'b1;
    step();
    check("pend_consumed", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 6'(i * 13);
      step();
      check("ff_od", out_data, 1);
    end
    in_valid = 1'b0;

    // Reset after 4 bytes of a new load, with a result pending.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 6'd1;
    step();
    in_valid = 1'b0;
    check("rst_pend_ov", out_valid, 1);
    for (int k = 0; k < 4; k++) send_byte(8'h0F, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_loaded", loaded, 0);
    check("mrst_err", load_err, 0);
    check("mrst_ov", out_valid, 0);
    in_valid = 1'b1;
    #1;
    check("mrst_inrdy", in_ready, 0);
    in_valid = 1'b0;

    // Fresh load starts at byte 0: 0x01 sets entries 0,8,..,56 only.
    load_table(8'h01);
    check("fresh_loaded", loaded, 1);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 6'd8;
    step();
    check("fresh_od8", out_data, 1);
    in_data = 6'd9;
    step();
    check("fresh_od9", out_data, 0);
    in_data = 6'd56;
    step();
    check("fresh_od56", out_data, 1);
    in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
